stage_load_sequencer: RTL and testbench
=======================================

Name: stage_load_sequencer

Overview:
Sits between execute and stage_memory_load. Accepts a load request (rs1 base, immediate, funct3) from execute and computes the effective address. Drives stage_memory_load with word-aligned accesses, splitting misaligned loads into two consecutive word reads. Extracts and sign- or zero-extends the addressed bytes and returns the rd value to writeback.

Parameters:
IMM_WIDTH, 12, width of the signed immediate offset; sign-extended to XLEN.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk)
req_valid  input  1  execute presents a load request
req_ready  output  1  sequencer can accept a request (high only in IDLE)
req_base  input  XLEN  rs1 value
req_offset  input  IMM_WIDTH  signed immediate
req_funct3  input  3  LB=000 LH=001 LW=010 LBU=100 LHU=101
load_enable  output  1  to stage_memory_load enable
load_addr  output  XLEN  word-aligned address to stage_memory_load
load_complete  input  1  from stage_memory_load is_complete
load_value  input  XLEN  from stage_memory_load loaded_value
resp_valid  output  1  one-cycle pulse: result valid
resp_data  output  XLEN  extended load result
resp_fault  output  1  qualifies resp_valid: invalid funct3

Behaviour:
- Reset values: req_ready=0, load_enable=0, load_addr=0, resp_valid=0, resp_data=0, resp_fault=0; state IDLE. req_ready rises the cycle after reset deasserts.
- States: IDLE, ISSUE0, GAP, ISSUE1, RESP.
- IDLE: req_ready=1. On req_valid, latch:
  - ea = req_base + sext(req_offset), mod 2^XLEN
  - off = ea[1:0]
  - size = 1/2/4 by funct3[1:0]
  - unsigned = funct3[2]
  - split = (off + size > 4)
- IDLE transitions:
  - Invalid funct3 (011, 110, 111): go to RESP with fault; no memory access.
  - Otherwise: go to ISSUE0.
- ISSUE0: load_enable=1, load_addr={ea[XLEN-1:2],2'b00}.
  - load_addr is stable for the whole time load_enable is high.
  - On load_complete: capture w0 = load_value and deassert load_enable next cycle.
  - Next state is GAP if split, else RESP.
- GAP: load_enable=0 for exactly one cycle so stage_memory_load clears its completion. Then go to ISSUE1.
- ISSUE1: load_addr = word0 address + 4, wrapping (0xFFFFFFFC -> 0x00000000). On load_complete: capture w1 and go to RESP.
- Only a load_complete sampled while load_enable=1 in ISSUE0/ISSUE1 is honoured; it is ignored in every other state.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure.
  - resp_data = low size bytes of ({w1,w0} >> 8*off), little-endian.
  - Sign-extended from the top byte when unsigned=0, zero-extended when unsigned=1.
  - For non-split loads w1 is don't-care.
  - resp_data and resp_fault are registered and hold their values until the next RESP.
- Fault: resp_fault=1 and resp_data=0 in RESP. Fault latency is accept + 1 cycle.
- Latency:
  - Aligned/non-split: request accepted at edge T; load_enable high from T+1. If load_complete is first high at cycle C, resp_valid is high at C+1.
  - Split: adds the GAP cycle plus the second access.
- Reset mid-operation: all outputs return to reset values at the next edge. Any in-flight access is abandoned: load_enable falls and no response is issued.

Decomposition:
- Shared core package: XLEN, the funct3 load encodings, and the state enum type.
- One natural sub-module: load_extract (combinational). Inputs: {w1,w0}, off, size, unsigned. Output: XLEN result. It is unit-testable on its own.

Test Plan:
- Bench memory: mem[0x1000]=0xAB12CD34, mem[0x1004]=0xEF56AB78. The bench model asserts load_complete one cycle after load_enable rises, with load_value from mem.
- LW base 0x1000 off 0 -> single access at 0x1000; resp_data=0xAB12CD34, resp_fault=0; resp_valid exactly 1 cycle.
- LB base 0x1004 off 0xFFF (-1) -> access 0x1000; resp_data=0xFFFFFFAB. LBU same address -> 0x000000AB.
- LH at ea 0x1003 (split) -> load_enable low exactly one cycle between accesses at 0x1000 and 0x1004; resp_data=0x000078AB. LW at ea 0x1002 -> 0xAB78AB12.
- Wrap: LW base 0xFFFFFFFC off 2 -> accesses at 0xFFFFFFFC then 0x00000000.
- funct3=011 -> load_enable never asserted; resp_valid one cycle after accept, resp_fault=1, resp_data=0.
- Reset low while in ISSUE0 -> load_enable=0 and req_ready=0 the next cycle; no resp_valid. After reset release, a new LW at 0x1004 returns 0xEF56AB78.

Source files
------------

// File: rtl/stage_load_sequencer_pkg.sv
// Shared definitions for the load sequencer: data width, funct3 load
// encodings, FSM state type and small decode helpers.
package stage_load_sequencer_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_GAP,
        S_ISSUE1,
        S_RESP
    } state_t;

    // True for the five supported load encodings.
    function automatic logic f3_valid(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Access size in bytes (1, 2 or 4) from funct3[1:0].
    function automatic logic [2:0] f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/stage_load_sequencer_load_extract.sv
// Byte extraction for loads: shifts the two-word window right by the byte
// offset, keeps the low size bytes and sign- or zero-extends them.
module load_extract
    import stage_load_sequencer_pkg::*;
(
    input  logic [2*XLEN-1:0] words,
    input  logic [1:0]        off,
    input  logic [2:0]        size,
    input  logic              is_unsigned,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] shifted;

    assign shifted = XLEN'(words >> {off, 3'b000});

    // Select the addressed width and extend to XLEN.
    always_comb begin
        result = '0;
        case (size)
            3'd1:    result = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            3'd2:    result = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/stage_load_sequencer.sv
// Load sequencer between execute and stage_memory_load. Computes the
// effective address, issues one or two word-aligned reads (two when the
// access crosses a word boundary) and returns the extended result.
module stage_load_sequencer
    import stage_load_sequencer_pkg::*;
#(
    parameter int unsigned IMM_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [XLEN-1:0]      req_base,
    input  logic [IMM_WIDTH-1:0] req_offset,
    input  logic [2:0]           req_funct3,
    output logic                 load_enable,
    output logic [XLEN-1:0]      load_addr,
    input  logic                 load_complete,
    input  logic [XLEN-1:0]      load_value,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_data,
    output logic                 resp_fault
);

    state_t          state;
    state_t          state_next;

    logic [XLEN-1:0] ea_in;
    logic [2:0]      size_in;
    logic            split_in;
    logic            accept;

    logic [1:0]      off_q;
    logic [2:0]      size_q;
    logic            uns_q;
    logic            split_q;
    logic [XLEN-1:0] w0_q;

    logic [XLEN-1:0] ext_w0;
    logic [XLEN-1:0] ext_result;

    assign ea_in    = req_base + {{(XLEN-IMM_WIDTH){req_offset[IMM_WIDTH-1]}}, req_offset};
    assign size_in  = f3_size(req_funct3[1:0]);
    assign split_in = ({2'b00, ea_in[1:0]} + {1'b0, size_in}) > 4'd4;
    assign accept   = (state == S_IDLE) && req_ready && req_valid;

    assign load_enable = (state == S_ISSUE0) || (state == S_ISSUE1);
    assign resp_valid  = (state == S_RESP);

    // The extractor sees the completing word directly so the result can be
    // registered on the same edge the last access completes; in ISSUE1 the
    // first word comes from w0_q and the second from the bus.
    assign ext_w0 = (state == S_ISSUE1) ? w0_q : load_value;

    load_extract u_extract (
        .words       ({load_value, ext_w0}),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_result)
    );

    // Next-state logic for the request/issue/response sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = f3_valid(req_funct3) ? S_ISSUE0 : S_RESP;
                end
            end
            S_ISSUE0: begin
                if (load_complete) begin
                    state_next = split_q ? S_GAP : S_RESP;
                end
            end
            S_GAP: begin
                state_next = S_ISSUE1;
            end
            S_ISSUE1: begin
                if (load_complete) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, address sequencing, word capture and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready  <= 1'b0;
            load_addr  <= '0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            split_q    <= 1'b0;
            w0_q       <= '0;
        end else begin
            req_ready <= (state_next == S_IDLE);

            if (accept) begin
                off_q     <= ea_in[1:0];
                size_q    <= size_in;
                uns_q     <= req_funct3[2];
                split_q   <= split_in;
                load_addr <= {ea_in[XLEN-1:2], 2'b00};
                if (!f3_valid(req_funct3)) begin
                    resp_data  <= '0;
                    resp_fault <= 1'b1;
                end
            end

            if ((state == S_ISSUE0) && load_complete) begin
                w0_q <= load_value;
                if (split_q) begin
                    load_addr <= load_addr + XLEN'(4);
                end else begin
                    resp_data  <= ext_result;
                    resp_fault <= 1'b0;
                end
            end

            if ((state == S_ISSUE1) && load_complete) begin
                resp_data  <= ext_result;
                resp_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_load_sequencer.sv
// Testbench for stage_load_sequencer: a latency-configurable memory
// responder plus directed and randomized loads checked against a
// byte-level reference model.
module tb_stage_load_sequencer;
    import stage_load_sequencer_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_base;
    logic [11:0]     req_offset;
    logic [2:0]      req_funct3;
    logic            load_enable;
    logic [31:0]     load_addr;
    logic            load_complete;
    logic [31:0]     load_value;
    logic            resp_valid;
    logic [31:0]     resp_data;
    logic            resp_fault;

    int errors = 0;
    int checks = 0;
    int lat    = 0;
    bit stray  = 1'b0;

    always #5 clk = ~clk;

    stage_load_sequencer #(.IMM_WIDTH(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_base      (req_base),
        .req_offset    (req_offset),
        .req_funct3    (req_funct3),
        .load_enable   (load_enable),
        .load_addr     (load_addr),
        .load_complete (load_complete),
        .load_value    (load_value),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_fault    (resp_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] aw;
        aw = {a[31:2], 2'b00};
        if (aw == 32'h0000_1000) return 32'hAB12_CD34;
        if (aw == 32'h0000_1004) return 32'hEF56_AB78;
        return {aw[15:0], aw[31:16]} ^ 32'hA5C3_3C5A;
    endfunction

    function automatic int unsigned model_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reads byte by byte from memory and extends, independent of word splitting.
    function automatic logic [31:0] model_load(input logic [31:0] ea, input logic [2:0] f3);
        int unsigned n;
        logic [31:0] v, a, w;
        n = model_size(f3);
        v = '0;
        for (int unsigned i = 0; i < n; i++) begin
            a = ea + i;
            w = mem_word(a);
            v |= ((w >> (8 * a[1:0])) & 32'hFF) << (8 * i);
        end
        if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    function automatic bit model_fault(input logic [2:0] f3);
        return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
    endfunction

    // Memory responder: completes lat cycles after load_enable rises; optional
    // stray completes while load_enable is low must be ignored by the DUT.
    initial begin
        int cnt;
        bit done;
        cnt = 0;
        done = 1'b0;
        load_complete = 1'b0;
        load_value = '0;
        forever begin
            @(posedge clk);
            #1;
            if (load_enable) begin
                if (!done && cnt >= lat) begin
                    load_complete = 1'b1;
                    load_value = mem_word(load_addr);
                    done = 1'b1;
                end else begin
                    load_complete = 1'b0;
                    load_value = $urandom;
                    if (!done) cnt++;
                end
            end else begin
                cnt = 0;
                done = 1'b0;
                load_complete = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                load_value = $urandom;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete load transaction with protocol, timing and data checks.
    task automatic do_load(input string name, input logic [31:0] base, input logic [11:0] off,
                           input logic [2:0] f3, input logic [31:0] exp_data, input logic exp_fault);
        logic [31:0] ea, last;
        logic [31:0] exp_a[2];
        logic [31:0] got_a[2];
        int exp_n, n, first_k, last_c, resp_k, low_cnt;
        bit prev_en, got;
        logic [31:0] prev_addr;

        ea = base + {{20{off[11]}}, off};
        last = ea + model_size(f3) - 1;
        exp_a[0] = {ea[31:2], 2'b00};
        exp_a[1] = {last[31:2], 2'b00};
        exp_n = exp_fault ? 0 : (exp_a[1] != exp_a[0]) ? 2 : 1;
        got_a[0] = '0;
        got_a[1] = '0;
        n = 0; first_k = 0; last_c = 0; resp_k = 0; low_cnt = 0;
        prev_en = 1'b0; got = 1'b0; prev_addr = '0;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", name, req_ready);
        end

        req_valid = 1'b1; req_base = base; req_offset = off; req_funct3 = f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_base = $urandom; req_offset = 12'($urandom); req_funct3 = 3'($urandom);
        #1;

        for (int k = 1; k <= 60 && !got; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #2;
            end
            if (load_enable) begin
                if (!prev_en) begin
                    if (n < 2) got_a[n] = load_addr;
                    if (n == 0) first_k = k;
                    if (n == 1) begin
                        checks++;
                        if (low_cnt !== 1) begin
                            errors++;
                            $display("FAIL %s gap: got %0d low cycles want 1", name, low_cnt);
                        end
                    end
                    n++;
                    low_cnt = 0;
                end else begin
                    checks++;
                    if (load_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL %s addr_stable: got %h want %h", name, load_addr, prev_addr);
                    end
                end
                if (load_complete) last_c = k;
            end else if (n > 0) begin
                low_cnt++;
            end
            if (resp_valid) begin
                got = 1'b1;
                resp_k = k;
            end
            prev_en = load_enable;
            prev_addr = load_addr;
        end

        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: got no resp_valid want resp_valid", name);
            reset = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #2;
            return;
        end

        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL %s accesses: got %0d want %0d", name, n, exp_n);
        end
        for (int i = 0; i < exp_n && i < n; i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL %s access%0d_addr: got %h want %h", name, i, got_a[i], exp_a[i]);
            end
        end
        if (exp_n > 0) begin
            checks++;
            if (first_k !== 1) begin
                errors++;
                $display("FAIL %s enable_latency: got cycle %0d want 1", name, first_k);
            end
        end
        checks++;
        if (resp_k !== ((exp_n == 0) ? 1 : last_c + 1)) begin
            errors++;
            $display("FAIL %s resp_latency: got cycle %0d want %0d", name, resp_k,
                     (exp_n == 0) ? 1 : last_c + 1);
        end
        checks++;
        if (resp_data !== exp_data) begin
            errors++;
            $display("FAIL %s resp_data: got %h want %h", name, resp_data, exp_data);
        end
        checks++;
        if (resp_fault !== exp_fault) begin
            errors++;
            $display("FAIL %s resp_fault: got %b want %b", name, resp_fault, exp_fault);
        end

        @(posedge clk);
        #2;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_pulse: got %b want 0", name, resp_valid);
        end
        checks++;
        if (resp_data !== exp_data) begin
            errors++;
            $display("FAIL %s resp_hold: got %h want %h", name, resp_data, exp_data);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({req_ready, load_enable, resp_valid, resp_fault} !== 4'b0000) begin
            errors++;
            $display("FAIL %s ctrl: got rdy=%b en=%b rv=%b flt=%b want all 0",
                     name, req_ready, load_enable, resp_valid, resp_fault);
        end
        checks++;
        if (load_addr !== 32'h0) begin
            errors++;
            $display("FAIL %s load_addr: got %h want 0", name, load_addr);
        end
        checks++;
        if (resp_data !== 32'h0) begin
            errors++;
            $display("FAIL %s resp_data: got %h want 0", name, resp_data);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset");
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: got %b want 0", req_ready);
        end
        @(posedge clk);
        #2;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_directed();
        lat = 0;
        stray = 1'b0;
        do_load("lw_aligned",  32'h0000_1000, 12'h000, 3'b010, 32'hAB12_CD34, 1'b0);
        do_load("lb_negoff",   32'h0000_1004, 12'hFFF, 3'b000, 32'hFFFF_FFAB, 1'b0);
        do_load("lbu_negoff",  32'h0000_1004, 12'hFFF, 3'b100, 32'h0000_00AB, 1'b0);
        do_load("lh_split",    32'h0000_1000, 12'h003, 3'b001, 32'h0000_78AB, 1'b0);
        do_load("lw_split",    32'h0000_1000, 12'h002, 3'b010, 32'hAB78_AB12, 1'b0);
        lat = 2;
        do_load("lhu_split_slow", 32'h0000_1003, 12'h000, 3'b101, 32'h0000_78AB, 1'b0);
    endtask

    task automatic test_wrap();
        lat = 0;
        do_load("lw_wrap", 32'hFFFF_FFFC, 12'h002, 3'b010, model_load(32'hFFFF_FFFE, 3'b010), 1'b0);
    endtask

    task automatic test_fault();
        lat = 0;
        do_load("fault_011", 32'h0000_1000, 12'h000, 3'b011, 32'h0, 1'b1);
        do_load("after_fault", 32'h0000_1004, 12'h001, 3'b101, 32'h0000_56AB, 1'b0);
        do_load("fault_111", 32'h0000_1004, 12'h000, 3'b111, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        lat = 3;
        stray = 1'b0;
        req_valid = 1'b1; req_base = 32'h0000_1000; req_offset = 12'h000; req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1;
        checks++;
        if (load_enable !== 1'b1) begin
            errors++;
            $display("FAIL midreset_issue: got en=%b want 1", load_enable);
        end
        reset = 1'b0;
        @(posedge clk);
        #2;
        check_reset_outputs("midreset");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            checks++;
            if (resp_valid !== 1'b0 || load_enable !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet: got rv=%b en=%b want 0 0", resp_valid, load_enable);
            end
        end
        lat = 0;
        do_load("lw_after_reset", 32'h0000_1004, 12'h000, 3'b010, 32'hEF56_AB78, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] base, ea;
        logic [11:0] off;
        logic [2:0] f3;
        stray = 1'b1;
        for (int i = 0; i < 60; i++) begin
            base = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_1000 + $urandom_range(0, 15);
            off = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 7)) : 12'($urandom);
            f3 = 3'($urandom);
            lat = $urandom_range(0, 2);
            ea = base + {{20{off[11]}}, off};
            do_load($sformatf("rand%0d", i), base, off, f3,
                    model_fault(f3) ? 32'h0 : model_load(ea, f3), model_fault(f3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #2;
            end
        end
        stray = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0;
        req_base = '0;
        req_offset = '0;
        req_funct3 = '0;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        test_directed();
        test_wrap();
        test_fault();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
